dual_issue_decode: RTL

- Consumer end of the fetch-to-decode interface.
- Each cycle it takes the instruction pair presented by fetch and decodes both instructions. It checks intra-pair and load-use hazards, then issues zero, one or two decoded micro-ops to the register/execute stage.
- It drives the `stall` and `issingleinstr` controls back to fetch, and flushes on a taken branch.

---
 rtl/dual_issue_decode.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/dual_issue_decode.sv
// dual_issue_decode: decodes the fetched instruction pair and issues 0, 1 or 2 micro-ops.
// Resolves intra-pair and load-use hazards and splits pairs through a one-entry hold register.
`default_nettype none

module dual_issue_decode #(
    parameter bit DUAL_ISSUE      = 1'b1,
    parameter bit LOAD_USE_BUBBLE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr1,
    input  logic [15:0] instr2,
    input  logic        flush,
    output logic        stall,
    output logic        issingleinstr,
    output logic        s0_valid,
    output logic [3:0]  s0_op,
    output logic [2:0]  s0_rd,
    output logic        s0_we,
    output logic [2:0]  s0_ra,
    output logic [2:0]  s0_rb,
    output logic [15:0] s0_imm,
    output logic        s1_valid,
    output logic [3:0]  s1_op,
    output logic [2:0]  s1_rd,
    output logic        s1_we,
    output logic [2:0]  s1_ra,
    output logic [2:0]  s1_rb,
    output logic [15:0] s1_imm,
    output logic        illegal
);

    localparam logic [3:0] OP_LW  = 4'h6;
    localparam logic [3:0] OP_SW  = 4'h7;
    localparam logic [3:0] OP_BEQ = 4'h8;
    localparam logic [3:0] OP_JMP = 4'h9;

    typedef enum logic [0:0] {NORMAL = 1'b0, SPLIT = 1'b1} state_t;

    typedef struct packed {
        logic        valid;
        logic [3:0]  op;
        logic [2:0]  rd;
        logic        we;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [15:0] imm;
    } slot_t;

    // Illegal and NOP words decode to an all-zero (invalid) slot.
    function automatic slot_t decode(input logic [15:0] w);
        slot_t u;
        u = '0;
        case (w[15:12])
            4'h1, 4'h2, 4'h3, 4'h4: begin
                u.valid = 1'b1; u.op = w[15:12]; u.rd = w[11:9]; u.we = 1'b1;
                u.ra = w[8:6]; u.rb = w[5:3];
            end
            4'h5, 4'h6: begin
                u.valid = 1'b1; u.op = w[15:12]; u.rd = w[11:9]; u.we = 1'b1;
                u.ra = w[8:6]; u.imm = {{10{w[5]}}, w[5:0]};
            end
            4'h7: begin
                u.valid = 1'b1; u.op = w[15:12]; u.ra = w[8:6]; u.rb = w[11:9];
                u.imm = {{10{w[5]}}, w[5:0]};
            end
            4'h8: begin
                u.valid = 1'b1; u.op = w[15:12]; u.ra = w[11:9]; u.rb = w[8:6];
                u.imm = {{10{w[5]}}, w[5:0]};
            end
            4'h9: begin
                u.valid = 1'b1; u.op = w[15:12]; u.imm = {{4{w[11]}}, w[11:0]};
            end
            default: u = '0;
        endcase
        return u;
    endfunction

    function automatic logic reads(input slot_t u, input logic [2:0] r);
        return (r != 3'd0) && ((u.ra == r) || (u.rb == r));
    endfunction

    function automatic logic [2:0] ld_rd(input slot_t u);
        return (u.op == OP_LW) ? u.rd : 3'd0;
    endfunction

    state_t      state_q, state_d;
    logic [15:0] hold_q, hold_d;
    logic [2:0]  lwrd_q, lwrd_d;
    slot_t       s0_q, s0_d, s1_q, s1_d;
    logic        ill_q, ill_d;

    slot_t w_a, w_b, w_h;
    logic  w_a_ill, w_b_ill, w_h_ill;
    logic  w_dual_ok;

    assign w_a     = decode(instr1);
    assign w_b     = decode(instr2);
    assign w_h     = decode(hold_q);
    assign w_a_ill = (instr1[15:12] >= 4'hA);
    assign w_b_ill = (instr2[15:12] >= 4'hA);
    assign w_h_ill = (hold_q[15:12] >= 4'hA);

    assign w_dual_ok = DUAL_ISSUE
                     && !(w_a.we && reads(w_b, w_a.rd))
                     && !(w_a.we && w_b.we && (w_a.rd == w_b.rd) && (w_a.rd != 3'd0))
                     && !(((w_a.op == OP_LW) || (w_a.op == OP_SW)) &&
                          ((w_b.op == OP_LW) || (w_b.op == OP_SW)))
                     && !((w_a.op == OP_BEQ) || (w_a.op == OP_JMP));

    assign issingleinstr = (state_q == SPLIT) || !DUAL_ISSUE;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        lwrd_d  = lwrd_q;
        s0_d    = '0;
        s1_d    = '0;
        ill_d   = 1'b0;
        stall   = 1'b0;
        if (flush) begin
            state_d = NORMAL;
            hold_d  = '0;
            lwrd_d  = '0;
        end else if (state_q == SPLIT) begin
            if (LOAD_USE_BUBBLE && reads(w_h, lwrd_q)) begin
                stall  = 1'b1;
                lwrd_d = '0;
            end else begin
                s0_d    = w_h;
                ill_d   = w_h_ill;
                lwrd_d  = ld_rd(w_h);
                hold_d  = '0;
                state_d = NORMAL;
            end
        end else if (LOAD_USE_BUBBLE && (reads(w_a, lwrd_q) || reads(w_b, lwrd_q))) begin
            stall  = 1'b1;
            lwrd_d = '0;
        end else if (w_dual_ok) begin
            s0_d   = w_a;
            s1_d   = w_b;
            ill_d  = w_a_ill | w_b_ill;
            lwrd_d = ld_rd(w_a) | ld_rd(w_b);
        end else begin
            s0_d   = w_a;
            ill_d  = w_a_ill;
            lwrd_d = ld_rd(w_a);
            if (instr2[15:12] != 4'h0) begin
                hold_d  = instr2;
                stall   = 1'b1;
                state_d = SPLIT;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= NORMAL;
            hold_q  <= '0;
            lwrd_q  <= '0;
            s0_q    <= '0;
            s1_q    <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            lwrd_q  <= lwrd_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            ill_q   <= ill_d;
        end
    end

    assign s0_valid = s0_q.valid;
    assign s0_op    = s0_q.op;
    assign s0_rd    = s0_q.rd;
    assign s0_we    = s0_q.we;
    assign s0_ra    = s0_q.ra;
    assign s0_rb    = s0_q.rb;
    assign s0_imm   = s0_q.imm;
    assign s1_valid = s1_q.valid;
    assign s1_op    = s1_q.op;
    assign s1_rd    = s1_q.rd;
    assign s1_we    = s1_q.we;
    assign s1_ra    = s1_q.ra;
    assign s1_rb    = s1_q.rb;
    assign s1_imm   = s1_q.imm;
    assign illegal  = ill_q;

endmodule

`default_nettype wire
